// File: rtl/fifo_drv_pkg.sv
// fifo_drv_pkg: shared types and widths for the FIFO write driver and its interface
// Contents: state_t (IDLE/WRITE/GAP), DATA_W (write data width), PTR_W (write pointer width)
package fifo_drv_pkg;
    localparam int DATA_W = 16;
    localparam int PTR_W = 5;
    typedef enum logic [1:0] {IDLE, WRITE, GAP} state_t;
endpackage

// File: rtl/fifo_write_driver_if.sv
// fifo_write_driver_if: FIFO write-port bundle between the pattern driver and the FIFO
// Signals: wr_en (write strobe), wr_data (write word), full (FIFO full, CLOCK_50 domain)
// Modports: master = driver side, slave = FIFO side
interface fifo_write_driver_if;
    import fifo_drv_pkg::*;
    logic              wr_en;
    logic [DATA_W-1:0] wr_data;
    logic              full;
    modport master(output wr_en, output wr_data, input full);
    modport slave(input wr_en, input wr_data, output full);
endinterface

// File: rtl/fifo_write_driver_tick_gen.sv
// tick_gen: one-cycle enable tick every DIV clocks, free running from reset
// Ports: CLOCK_50 (clock), rst (sync active-high reset), tick (high when counter is DIV-1)
module tick_gen #(
    parameter int DIV = 50000000
) (
    input  logic CLOCK_50,
    input  logic rst,
    output logic tick
);
    localparam int CW = $clog2(DIV);
    logic [CW-1:0] cnt;
    assign tick = cnt == CW'(DIV - 1);
    always_ff @(posedge CLOCK_50) cnt <= (rst || tick) ? '0 : cnt + CW'(1);
endmodule

// File: rtl/fifo_write_driver.sv
// fifo_write_driver: paced burst writer pushing an incrementing data pattern into a FIFO
// Ports: CLOCK_50 (clock), rst (sync active-high reset), run (level, keep bursting),
//        fifo (master: wr_en, wr_data out; full in), wr_ptr (accepted writes mod 32),
//        busy (in WRITE or GAP), burst_done (pulse with last write of a burst),
//        stall_cnt (ticks lost to full, saturating at 255)
module fifo_write_driver
    import fifo_drv_pkg::*;
#(
    parameter int                DIV       = 50000000,
    parameter int                BURST_LEN = 8,
    parameter int                GAP_TICKS = 4,
    parameter logic [DATA_W-1:0] SEED      = 16'h0001,
    parameter logic [DATA_W-1:0] STEP      = 16'h0001
) (
    input  logic                CLOCK_50,
    input  logic                rst,
    input  logic                run,
    fifo_write_driver_if.master fifo,
    output logic [PTR_W-1:0]    wr_ptr,
    output logic                busy,
    output logic                burst_done,
    output logic [7:0]          stall_cnt
);
    state_t            state;
    logic [DATA_W-1:0] next_data;
    logic [7:0]        words_left;
    logic [7:0]        gap_cnt;
    logic              tick;
    tick_gen #(.DIV(DIV)) u_tick (
        .CLOCK_50(CLOCK_50),
        .rst(rst),
        .tick(tick)
    );
    // run is only looked at in IDLE and at burst/gap exits, so a dropped run
    // still lets the current burst finish, stalls included.
    always_ff @(posedge CLOCK_50) begin
        if (rst) begin
            state        <= IDLE;
            next_data    <= SEED;
            words_left   <= '0;
            gap_cnt      <= '0;
            fifo.wr_en   <= 1'b0;
            fifo.wr_data <= '0;
            wr_ptr       <= '0;
            busy         <= 1'b0;
            burst_done   <= 1'b0;
            stall_cnt    <= '0;
        end else begin
            fifo.wr_en <= 1'b0;
            burst_done <= 1'b0;
            case (state)
                IDLE: if (run) begin
                    state      <= WRITE;
                    busy       <= 1'b1;
                    words_left <= 8'(BURST_LEN);
                end
                WRITE: if (tick && fifo.full) begin
                    stall_cnt <= stall_cnt + 8'(stall_cnt != 8'hFF);
                end else if (tick) begin
                    fifo.wr_en   <= 1'b1;
                    fifo.wr_data <= next_data;
                    next_data    <= next_data + STEP;
                    wr_ptr       <= wr_ptr + PTR_W'(1);
                    words_left   <= words_left - 8'd1;
                    if (words_left == 8'd1) begin
                        burst_done <= 1'b1;
                        if (GAP_TICKS > 0) begin
                            state   <= GAP;
                            gap_cnt <= 8'(GAP_TICKS);
                        end else if (run) begin
                            words_left <= 8'(BURST_LEN);
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                GAP: if (tick) begin
                    gap_cnt <= gap_cnt - 8'd1;
                    if (gap_cnt == 8'd1) begin
                        if (run) begin
                            state      <= WRITE;
                            words_left <= 8'(BURST_LEN);
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fifo_write_driver.sv
// tb_fifo_write_driver: scenario and randomized checks of the paced FIFO write driver
module tb_fifo_write_driver;
    logic CLOCK_50 = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;
    logic       rst = 1'b1;
    logic       run = 1'b0;
    logic       run1 = 1'b0;
    logic [4:0] ptr0, ptr1;
    logic       busy0, busy1, bd0, bd1;
    logic [7:0] st0, st1;
    fifo_write_driver_if f0();
    fifo_write_driver_if f1();
    fifo_write_driver #(.DIV(4), .BURST_LEN(4), .GAP_TICKS(2), .SEED(16'h0010), .STEP(16'h0001)) u0 (
        .CLOCK_50(CLOCK_50), .rst(rst), .run(run), .fifo(f0),
        .wr_ptr(ptr0), .busy(busy0), .burst_done(bd0), .stall_cnt(st0)
    );
    fifo_write_driver #(.DIV(4), .BURST_LEN(40), .GAP_TICKS(2), .SEED(16'hFFFE), .STEP(16'h0001)) u1 (
        .CLOCK_50(CLOCK_50), .rst(rst), .run(run1), .fifo(f1),
        .wr_ptr(ptr1), .busy(busy1), .burst_done(bd1), .stall_cnt(st1)
    );
    int errors = 0;
    int checks = 0;
    int cyc;
    always @(posedge CLOCK_50) cyc <= rst ? 0 : cyc + 1;
    typedef struct {
        int         c;
        logic [15:0] d;
        logic [4:0]  p;
        logic        b;
    } wr_t;
    wr_t q0[$];
    wr_t q1[$];
    wr_t m0, m1;
    always @(negedge CLOCK_50) begin
        if (!rst && f0.wr_en === 1'b1) begin
            m0.c = cyc; m0.d = f0.wr_data; m0.p = ptr0; m0.b = bd0;
            q0.push_back(m0);
        end
        if (!rst && f1.wr_en === 1'b1) begin
            m1.c = cyc; m1.d = f1.wr_data; m1.p = ptr1; m1.b = bd1;
            q1.push_back(m1);
        end
    end

    task automatic do_reset();
        @(negedge CLOCK_50);
        rst = 1'b1; run = 1'b0; run1 = 1'b0; f0.full = 1'b0;
        repeat (2) @(negedge CLOCK_50);
        q0.delete(); q1.delete();
        rst = 1'b0;
    endtask

    task automatic wait_cyc(input int k);
        while (cyc < k) @(negedge CLOCK_50);
    endtask

    task automatic test_reset();
        @(negedge CLOCK_50);
        rst = 1'b1; run = 1'b0; f0.full = 1'b0;
        repeat (2) @(negedge CLOCK_50);
        checks++; if (f0.wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en got=%b exp=0", f0.wr_en); end
        checks++; if (f0.wr_data !== 16'h0) begin errors++; $display("FAIL reset_wr_data got=%h exp=0000", f0.wr_data); end
        checks++; if (ptr0 !== 5'd0) begin errors++; $display("FAIL reset_wr_ptr got=%0d exp=0", ptr0); end
        checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy0); end
        checks++; if (bd0 !== 1'b0) begin errors++; $display("FAIL reset_burst_done got=%b exp=0", bd0); end
        checks++; if (st0 !== 8'd0) begin errors++; $display("FAIL reset_stall_cnt got=%0d exp=0", st0); end
        rst = 1'b0;
    endtask

    // Write i lands on tick (i/4)*(4+2) + i%4 + 1: each burst of 4 is followed by 2 idle ticks.
    task automatic test_burst();
        int t;
        do_reset(); run = 1'b1;
        wait_cyc(22);
        checks++; if (busy0 !== 1'b1) begin errors++; $display("FAIL burst_busy_in_gap got=%b exp=1", busy0); end
        wait_cyc(42);
        checks++; if (q0.size() != 8) begin errors++; $display("FAIL burst_count got=%0d exp=8", q0.size()); end
        for (int i = 0; i < q0.size() && i < 8; i++) begin
            t = (i / 4) * 6 + i % 4 + 1;
            checks++; if (q0[i].c != 4 * t) begin errors++; $display("FAIL burst_cycle[%0d] got=%0d exp=%0d", i, q0[i].c, 4 * t); end
            checks++; if (q0[i].d !== 16'h0010 + 16'(i)) begin errors++; $display("FAIL burst_data[%0d] got=%h exp=%h", i, q0[i].d, 16'h0010 + 16'(i)); end
            checks++; if (q0[i].p !== 5'(i + 1)) begin errors++; $display("FAIL burst_ptr[%0d] got=%0d exp=%0d", i, q0[i].p, i + 1); end
            checks++; if (q0[i].b !== (i % 4 == 3)) begin errors++; $display("FAIL burst_done[%0d] got=%b exp=%b", i, q0[i].b, i % 4 == 3); end
        end
        run = 1'b0;
    endtask

    task automatic test_stall();
        int ec[4] = '{4, 20, 24, 28};
        do_reset(); run = 1'b1;
        while (cyc < 30) begin
            f0.full = (cyc >= 7 && cyc <= 15);
            @(negedge CLOCK_50);
        end
        f0.full = 1'b0;
        checks++; if (st0 !== 8'd3) begin errors++; $display("FAIL stall_cnt got=%0d exp=3", st0); end
        checks++; if (q0.size() != 4) begin errors++; $display("FAIL stall_count got=%0d exp=4", q0.size()); end
        for (int i = 0; i < q0.size() && i < 4; i++) begin
            checks++; if (q0[i].c != ec[i]) begin errors++; $display("FAIL stall_cycle[%0d] got=%0d exp=%0d", i, q0[i].c, ec[i]); end
            checks++; if (q0[i].d !== 16'h0010 + 16'(i)) begin errors++; $display("FAIL stall_data[%0d] got=%h exp=%h", i, q0[i].d, 16'h0010 + 16'(i)); end
        end
        run = 1'b0;
    endtask

    task automatic test_run_drop();
        do_reset(); run = 1'b1;
        wait_cyc(9); run = 1'b0;
        wait_cyc(22);
        checks++; if (busy0 !== 1'b1) begin errors++; $display("FAIL drop_busy_gap got=%b exp=1", busy0); end
        wait_cyc(26);
        checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL drop_busy_idle got=%b exp=0", busy0); end
        wait_cyc(60);
        checks++; if (q0.size() != 4) begin errors++; $display("FAIL drop_count got=%0d exp=4", q0.size()); end
        if (q0.size() == 4) begin
            checks++; if (q0[3].d !== 16'h0013) begin errors++; $display("FAIL drop_last_data got=%h exp=0013", q0[3].d); end
            checks++; if (q0[3].b !== 1'b1) begin errors++; $display("FAIL drop_burst_done got=%b exp=1", q0[3].b); end
        end
        checks++; if (ptr0 !== 5'd4) begin errors++; $display("FAIL drop_ptr got=%0d exp=4", ptr0); end
        checks++; if (f0.wr_data !== 16'h0013) begin errors++; $display("FAIL drop_hold_data got=%h exp=0013", f0.wr_data); end
    endtask

    task automatic test_wrap();
        do_reset(); run1 = 1'b1;
        wait_cyc(142);
        checks++; if (q1.size() != 35) begin errors++; $display("FAIL wrap_count got=%0d exp=35", q1.size()); end
        for (int i = 0; i < q1.size(); i++) begin
            checks++; if (q1[i].d !== 16'hFFFE + 16'(i)) begin errors++; $display("FAIL wrap_data[%0d] got=%h exp=%h", i, q1[i].d, 16'hFFFE + 16'(i)); end
            checks++; if (q1[i].p !== 5'((i + 1) % 32)) begin errors++; $display("FAIL wrap_ptr[%0d] got=%0d exp=%0d", i, q1[i].p, (i + 1) % 32); end
            checks++; if (q1[i].b !== 1'b0) begin errors++; $display("FAIL wrap_burst_done[%0d] got=%b exp=0", i, q1[i].b); end
        end
        if (q1.size() > 31) begin
            checks++; if (q1[30].p !== 5'd31 || q1[31].p !== 5'd0) begin errors++; $display("FAIL wrap_ptr_edge got=%0d,%0d exp=31,0", q1[30].p, q1[31].p); end
        end
        run1 = 1'b0;
    endtask

    task automatic test_saturate();
        do_reset(); run = 1'b1; f0.full = 1'b1;
        wait_cyc(1016);
        checks++; if (st0 !== 8'd254) begin errors++; $display("FAIL sat_254 got=%0d exp=254", st0); end
        wait_cyc(1020);
        checks++; if (st0 !== 8'd255) begin errors++; $display("FAIL sat_255 got=%0d exp=255", st0); end
        wait_cyc(1210);
        checks++; if (st0 !== 8'd255) begin errors++; $display("FAIL sat_hold got=%0d exp=255", st0); end
        checks++; if (q0.size() != 0) begin errors++; $display("FAIL sat_no_write got=%0d exp=0", q0.size()); end
        checks++; if (busy0 !== 1'b1) begin errors++; $display("FAIL sat_busy got=%b exp=1", busy0); end
        f0.full = 1'b0; run = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_reset(); run = 1'b1;
        wait_cyc(7);
        checks++; if (ptr0 !== 5'd1) begin errors++; $display("FAIL mid_pre_ptr got=%0d exp=1", ptr0); end
        rst = 1'b1;
        @(negedge CLOCK_50);
        checks++; if (f0.wr_en !== 1'b0) begin errors++; $display("FAIL mid_wr_en got=%b exp=0", f0.wr_en); end
        checks++; if (f0.wr_data !== 16'h0) begin errors++; $display("FAIL mid_wr_data got=%h exp=0000", f0.wr_data); end
        checks++; if (ptr0 !== 5'd0) begin errors++; $display("FAIL mid_ptr got=%0d exp=0", ptr0); end
        checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL mid_busy got=%b exp=0", busy0); end
        q0.delete();
        rst = 1'b0;
        wait_cyc(6);
        checks++; if (q0.size() != 1) begin errors++; $display("FAIL mid_restart_count got=%0d exp=1", q0.size()); end
        if (q0.size() == 1) begin
            checks++; if (q0[0].d !== 16'h0010 || q0[0].p !== 5'd1 || q0[0].c != 4) begin errors++; $display("FAIL mid_restart got=%h/%0d/%0d exp=0010/1/4", q0[0].d, q0[0].p, q0[0].c); end
        end
        run = 1'b0;
    endtask

    // Tick-level model: every 4th cycle is a tick; after each 4th accepted word
    // two ticks are idle; otherwise a tick writes unless full was high.
    task automatic test_random_full();
        int n = 0, skip = 0, stalls = 0;
        logic full_s = 1'b0, exp_en, exp_bd;
        logic [15:0] exp_d;
        logic [4:0] exp_p;
        do_reset(); run = 1'b1;
        for (int k = 0; k < 400; k++) begin
            if (cyc > 0) begin
                exp_en = 1'b0; exp_bd = 1'b0; exp_d = 16'h0; exp_p = 5'd0;
                if (cyc % 4 == 0) begin
                    if (skip > 0) skip--;
                    else if (full_s) stalls++;
                    else begin
                        exp_en = 1'b1; exp_d = 16'h0010 + 16'(n); exp_p = 5'((n + 1) % 32);
                        exp_bd = ((n + 1) % 4 == 0);
                        if (exp_bd) skip = 2;
                        n++;
                    end
                end
                checks++; if (f0.wr_en !== exp_en) begin errors++; $display("FAIL rand_wr_en cyc=%0d got=%b exp=%b", cyc, f0.wr_en, exp_en); end
                checks++; if (bd0 !== exp_bd) begin errors++; $display("FAIL rand_burst_done cyc=%0d got=%b exp=%b", cyc, bd0, exp_bd); end
                checks++; if (st0 !== 8'(stalls > 255 ? 255 : stalls)) begin errors++; $display("FAIL rand_stall cyc=%0d got=%0d exp=%0d", cyc, st0, stalls); end
                if (exp_en) begin
                    checks++; if (f0.wr_data !== exp_d) begin errors++; $display("FAIL rand_data cyc=%0d got=%h exp=%h", cyc, f0.wr_data, exp_d); end
                    checks++; if (ptr0 !== exp_p) begin errors++; $display("FAIL rand_ptr cyc=%0d got=%0d exp=%0d", cyc, ptr0, exp_p); end
                end
            end
            full_s = ($urandom_range(0, 2) == 0);
            f0.full = full_s;
            @(negedge CLOCK_50);
        end
        f0.full = 1'b0; run = 1'b0;
    endtask

    initial begin
        f0.full = 1'b0;
        f1.full = 1'b0;
        test_reset();
        test_burst();
        test_stall();
        test_run_drop();
        test_wrap();
        test_saturate();
        test_reset_mid();
        test_random_full();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/fifo_write_driver.md
Name: fifo_write_driver

Overview:
Write-side producer for the async FIFO test platform. It generates a deterministic 16-bit data pattern and pushes it into the FIFO write port in bursts, with an enable tick derived from CLOCK_50 rather than a divided clock. It honours the FIFO full flag and exposes a write pointer, a busy flag and a stall count for LED and debug display. It pairs with the existing read-side display logic.

Parameters:
DIV, 26'd50000000, CLOCK_50 cycles per write tick; legal range is at least 2.
BURST_LEN, 8, words written per burst; legal range 1..255.
GAP_TICKS, 4, idle ticks between bursts; 0 is allowed.
SEED, 16'h0001, first data word after reset.
STEP, 16'h0001, data increment per accepted write.

Ports:
CLOCK_50  in  1  system clock; the only clock.
rst  in  1  synchronous, active-high reset.
run  in  1  level; start bursts and keep bursting while high.
full  in  1  FIFO full, synchronous to CLOCK_50.
wr_en  out  1  one-cycle FIFO write strobe.
wr_data  out  16  FIFO write data.
wr_ptr  out  5  count of accepted writes, mod 32.
busy  out  1  high in WRITE and GAP states.
burst_done  out  1  one-cycle pulse when the last word of a burst is written.
stall_cnt  out  8  ticks lost to full, saturating.

Behaviour:
- Reset: sampled on the CLOCK_50 posedge while rst=1. All registers clear and the state is IDLE.
  - Output values: wr_en=0, wr_data=0, wr_ptr=0, busy=0, burst_done=0, stall_cnt=0.
  - Internal values: next data = SEED, tick counter = 0.
  - Reset mid-burst aborts immediately, with no partial strobe.
- Tick generation: the counter runs 0..DIV-1 continuously in every state. tick=1 in the cycle where the counter equals DIV-1, then the counter wraps to 0.
- States are IDLE, WRITE and GAP.
  - IDLE: the tick counter still runs. On run=1, go to WRITE and set words_left=BURST_LEN.
  - WRITE, on a tick with full=0: accept a write.
    - wr_en=1 in the next cycle only. wr_data is the current next-data value.
    - next data += STEP, mod 2^16. wr_ptr += 1, mod 32. words_left -= 1.
  - WRITE, on a tick with full=1: no write. stall_cnt += 1, saturating at 255. Stay in WRITE.
  - WRITE, last accepted word:
    - burst_done=1 in the same cycle as that wr_en.
    - If GAP_TICKS>0, go to GAP with gap_cnt=GAP_TICKS.
    - If GAP_TICKS=0, go to WRITE when run=1, otherwise IDLE.
  - GAP: decrement gap_cnt on each tick. When it reaches 0, go to WRITE with words_left=BURST_LEN if run=1, otherwise IDLE.
- run deasserted mid-burst: the burst completes, including stalls, then the block stops after its GAP. run is sampled only at IDLE and at the GAP or burst exit.
- Latency: wr_en and wr_data are registered and appear 1 cycle after the tick.
  - full is sampled on the tick cycle.
  - Because DIV≥2, FIFO full caused by a write is visible by the next tick.
- wr_data holds its last written value while wr_en=0.
- wr_en never asserts in IDLE or GAP, and never in two consecutive cycles.
- Data wraps from 16'hFFFF to 16'h0000 without a flag. wr_ptr wraps from 31 to 0.

Decomposition:
- Shared package fifo_drv_pkg holds:
  - the state enum, 2 bits: IDLE, WRITE, GAP;
  - the constants DATA_W=16 and PTR_W=5.
- Sub-module tick_gen, parameter DIV, ports CLOCK_50, rst and tick. It is reusable for read-side pacing.
- The FSM, data generator and counters stay in fifo_write_driver.

Test Plan:
All cases use DIV=4, BURST_LEN=4, GAP_TICKS=2, SEED=16'h0010, STEP=1 unless noted.
1. run=1 from reset, full=0 → wr_en pulses every 4 cycles.
   - wr_data = 0010, 0011, 0012, 0013.
   - burst_done with the 4th pulse.
   - No strobe for 2 ticks, then the next burst starts at 0014. wr_ptr reaches 4 after the first burst.
2. full=1 held for 3 ticks during a burst → stall_cnt=3 and no wr_en during those ticks. The data sequence resumes with no skipped value.
3. run dropped after the 2nd write → the remaining 2 words are still written, then GAP, then IDLE with busy=0. No further wr_en.
4. Pointer and data wrap, with SEED=16'hFFFE and BURST_LEN=40:
   - wr_data goes FFFE, FFFF, 0000, 0001.
   - wr_ptr goes 31→0 on the 32nd write.
5. full=1 for 300 ticks → stall_cnt saturates at 255 and stays there.
6. rst=1 one cycle after a tick → no wr_en in the following cycle. All outputs are 0 next edge. The restart begins again at SEED.
